// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: branch control from decode, instruction memory port and the IF/ID register outputs.
`default_nettype none

interface fetch_stage_if;
   logic        stall;
   logic        take_branch;
   logic        uncond_br;
   logic        br_reg;
   logic [25:0] BrAddr26;
   logic [18:0] CondAddr19;
   logic [63:0] Db_br;
   logic [31:0] imem_data;
   logic [63:0] imem_addr;
   logic [31:0] instr_D;
   logic [63:0] pc_D;
   logic        valid_D;

   // master drives control and instruction data; slave is the fetch stage
   modport master (
      output stall, take_branch, uncond_br, br_reg, BrAddr26, CondAddr19, Db_br, imem_data,
      input  imem_addr, instr_D, pc_D, valid_D
   );

   modport slave (
      input  stall, take_branch, uncond_br, br_reg, BrAddr26, CondAddr19, Db_br, imem_data,
      output imem_addr, instr_D, pc_D, valid_D
   );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : Program counter, branch redirect and IF/ID pipeline register.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter real         DELAY     = 0.05,
   parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
   input  wire logic clk,
   input  wire logic reset,
   fetch_stage_if.slave bus
);

   // DELAY only annotates gate-level netlists; a negative value is meaningless.
   if (DELAY < 0.0) begin : g_delay_invalid
   end

   // PCs are kept as word addresses so bits [1:0] are zero by construction.
   logic [61:0] pc_word;
   logic [61:0] pc_d_word;
   logic [31:0] instr_d;
   logic        valid_d;

   logic [61:0] offset_word;
   logic [61:0] rel_target;
   logic [61:0] reg_target;
   logic [61:0] branch_target;

   always_comb begin
      if (bus.uncond_br)
         offset_word = {{36{bus.BrAddr26[25]}}, bus.BrAddr26};
      else
         offset_word = {{43{bus.CondAddr19[18]}}, bus.CondAddr19};
      // Relative targets are based on the instruction in decode, not the fetch PC.
      rel_target    = pc_d_word + offset_word;
      reg_target    = bus.Db_br[63:2];
      branch_target = bus.br_reg ? reg_target : rel_target;
   end

   // Branch squashes the wrong-path fetch and keeps pc_D; stall freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_word   <= '0;
         pc_d_word <= '0;
         instr_d   <= NOP_INSTR;
         valid_d   <= 1'b0;
      end else if (bus.take_branch) begin
         pc_word   <= branch_target;
         instr_d   <= NOP_INSTR;
         valid_d   <= 1'b0;
      end else if (!bus.stall) begin
         pc_word   <= pc_word + 62'd1;
         pc_d_word <= pc_word;
         instr_d   <= bus.imem_data;
         valid_d   <= 1'b1;
      end
   end

   assign bus.imem_addr = {pc_word, 2'b00};
   assign bus.pc_D      = {pc_d_word, 2'b00};
   assign bus.instr_D   = instr_d;
   assign bus.valid_D   = valid_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Directed vector table plus randomized run against a rule-level model of the fetch stage.
`default_nettype none

module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h8B1F03FF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_stage_if bus ();

   fetch_stage #(.DELAY(0.05), .NOP_INSTR(NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Instruction memory: word at byte address a is 0xA0 + a/4 (mod 2^32).
   function automatic logic [31:0] imem_f(input logic [63:0] a);
      return 32'h000000A0 + a[33:2];
   endfunction
   assign bus.imem_data = imem_f(bus.imem_addr);

   typedef struct {
      logic        rst;
      logic        stall;
      logic        tb;
      logic        unc;
      logic        brr;
      logic [25:0] b26;
      logic [18:0] c19;
      logic [63:0] db;
      logic [63:0] e_addr;
      logic [31:0] e_instr;
      logic [63:0] e_pcd;
      logic        e_valid;
   } vec_t;

   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(input logic rst, input logic stall, input logic tb, input logic unc,
                               input logic brr, input logic [25:0] b26, input logic [18:0] c19,
                               input logic [63:0] db, input logic [63:0] ea, input logic [31:0] ei,
                               input logic [63:0] ep, input logic ev);
      vec_t v;
      v.rst = rst; v.stall = stall; v.tb = tb; v.unc = unc; v.brr = brr;
      v.b26 = b26; v.c19 = c19; v.db = db;
      v.e_addr = ea; v.e_instr = ei; v.e_pcd = ep; v.e_valid = ev;
      return v;
   endfunction

   task automatic drive(input logic rst, input logic stall, input logic tb, input logic unc,
                        input logic brr, input logic [25:0] b26, input logic [18:0] c19,
                        input logic [63:0] db);
      reset = rst; bus.stall = stall; bus.take_branch = tb; bus.uncond_br = unc;
      bus.br_reg = brr; bus.BrAddr26 = b26; bus.CondAddr19 = c19; bus.Db_br = db;
   endtask

   task automatic check_all(input string tag, input int idx, input logic [63:0] ea,
                            input logic [31:0] ei, input logic [63:0] ep, input logic ev);
      checks += 4;
      if (bus.imem_addr !== ea) begin
         errors++; $display("FAIL %s[%0d] imem_addr got %h expected %h", tag, idx, bus.imem_addr, ea);
      end
      if (bus.instr_D !== ei) begin
         errors++; $display("FAIL %s[%0d] instr_D got %h expected %h", tag, idx, bus.instr_D, ei);
      end
      if (bus.pc_D !== ep) begin
         errors++; $display("FAIL %s[%0d] pc_D got %h expected %h", tag, idx, bus.pc_D, ep);
      end
      if (bus.valid_D !== ev) begin
         errors++; $display("FAIL %s[%0d] valid_D got %b expected %b", tag, idx, bus.valid_D, ev);
      end
   endtask

   vec_t vecs[26];

   // Reference model state
   logic [63:0] m_pc, m_pcd;
   logic [31:0] m_instr;
   logic        m_valid;

   initial begin
      vecs[0]  = mk(1,0,0,0,0,26'h0,19'h0,64'h0, 64'h0, NOP, 64'h0, 0);
      vecs[1]  = mk(1,0,0,0,0,26'h0,19'h0,64'h0, 64'h0, NOP, 64'h0, 0);
      vecs[2]  = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h4, 32'hA0, 64'h0, 1);
      vecs[3]  = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h8, 32'hA1, 64'h4, 1);
      vecs[4]  = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'hC, 32'hA2, 64'h8, 1);
      vecs[5]  = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h10, 32'hA3, 64'hC, 1);
      vecs[6]  = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h14, 32'hA4, 64'h10, 1);
      // B -2 from pc_D 0x10
      vecs[7]  = mk(0,0,1,1,0,26'h3FFFFFE,19'h0,64'h0, 64'h8, NOP, 64'h10, 0);
      vecs[8]  = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'hC, 32'hA2, 64'h8, 1);
      vecs[9]  = mk(0,0,1,1,0,26'h6,19'h0,64'h0, 64'h20, NOP, 64'h8, 0);
      vecs[10] = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h24, 32'hA8, 64'h20, 1);
      // conditional +3 with stall: branch wins
      vecs[11] = mk(0,1,1,0,0,26'h0,19'h3,64'h0, 64'h2C, NOP, 64'h20, 0);
      // register target overrides uncond_br
      vecs[12] = mk(0,0,1,1,1,26'h5,19'h0,64'h1003, 64'h1000, NOP, 64'h20, 0);
      vecs[13] = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h1004, 32'h4A0, 64'h1000, 1);
      vecs[14] = mk(0,0,1,0,1,26'h0,19'h0,64'h40, 64'h40, NOP, 64'h1000, 0);
      vecs[15] = mk(0,1,0,0,0,26'h0,19'h0,64'h0, 64'h40, NOP, 64'h1000, 0);
      vecs[16] = mk(0,1,0,0,0,26'h0,19'h0,64'h0, 64'h40, NOP, 64'h1000, 0);
      vecs[17] = mk(0,1,0,0,0,26'h0,19'h0,64'h0, 64'h40, NOP, 64'h1000, 0);
      vecs[18] = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h44, 32'hB0, 64'h40, 1);
      vecs[19] = mk(0,0,1,0,1,26'h0,19'h0,64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'h40, 0);
      // PC wraps to zero
      vecs[20] = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h0, 32'h9F, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      vecs[21] = mk(1,0,1,1,0,26'h5,19'h0,64'h0, 64'h0, NOP, 64'h0, 0);
      vecs[22] = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h4, 32'hA0, 64'h0, 1);
      vecs[23] = mk(0,1,0,0,0,26'h0,19'h0,64'h0, 64'h4, 32'hA0, 64'h0, 1);
      vecs[24] = mk(1,1,0,0,0,26'h0,19'h0,64'h0, 64'h0, NOP, 64'h0, 0);
      vecs[25] = mk(0,0,0,0,0,26'h0,19'h0,64'h0, 64'h4, 32'hA0, 64'h0, 1);

      drive(1,0,0,0,0,26'h0,19'h0,64'h0);
      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].tb, vecs[i].unc, vecs[i].brr,
               vecs[i].b26, vecs[i].c19, vecs[i].db);
         @(posedge clk); #1;
         check_all("vec", i, vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pcd, vecs[i].e_valid);
      end

      // Back-to-back redirects: both use the unchanged pc_D (0) and each leaves a bubble
      drive(0,0,1,1,0,26'h10,19'h0,64'h0);
      @(posedge clk); #1;
      check_all("br2a", 0, 64'h40, NOP, 64'h0, 1'b0);
      drive(0,0,1,1,0,26'h1,19'h0,64'h0);
      @(posedge clk); #1;
      check_all("br2b", 0, 64'h4, NOP, 64'h0, 1'b0);
      drive(0,0,0,0,0,26'h0,19'h0,64'h0);
      @(posedge clk); #1;
      check_all("br2c", 0, 64'h8, 32'hA1, 64'h4, 1'b1);

      // Randomized run against the rule-level model
      m_pc = 64'h8; m_instr = 32'hA1; m_pcd = 64'h4; m_valid = 1'b1;
      for (int n = 0; n < 400; n++) begin
         logic        r_rst, r_stall, r_tb, r_unc, r_brr;
         logic [25:0] r_b26;
         logic [18:0] r_c19;
         logic [63:0] r_db, off, tgt;
         r_rst   = ($urandom_range(0, 39) == 0);
         r_stall = ($urandom_range(0, 3) == 0);
         r_tb    = ($urandom_range(0, 4) == 0);
         r_unc   = $urandom_range(0, 1) == 1;
         r_brr   = ($urandom_range(0, 3) == 0);
         r_b26   = 26'($urandom);
         r_c19   = 19'($urandom);
         r_db    = {$urandom, $urandom};
         drive(r_rst, r_stall, r_tb, r_unc, r_brr, r_b26, r_c19, r_db);

         if (r_rst) begin
            m_pc = 0; m_instr = NOP; m_pcd = 0; m_valid = 0;
         end else if (r_tb) begin
            off = r_unc ? 64'(longint'($signed(r_b26))) : 64'(longint'($signed(r_c19)));
            if (r_brr) tgt = r_db & ~64'h3;
            else       tgt = m_pcd + off * 64'd4;
            m_pc = tgt; m_instr = NOP; m_valid = 0;
         end else if (!r_stall) begin
            m_instr = imem_f(m_pc); m_pcd = m_pc; m_pc = m_pc + 64'd4; m_valid = 1;
         end

         @(posedge clk); #1;
         check_all("rand", n, m_pc, m_instr, m_pcd, m_valid);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DELAY, default 0.05, gate delay in ns applied to primitive gates.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h8B1F03FF, bubble encoding (ADD X31,X31,X31).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, hold PC and IF/ID register this cycle.
REQ-006 SHALL have port take_branch, input, 1, branch in decode resolved taken.
REQ-007 SHALL have port uncond_br, input, 1, 1 selects BrAddr26 offset; 0 selects CondAddr19 offset.
REQ-008 SHALL have port br_reg, input, 1, 1 selects register target Db_br (BR).
REQ-009 SHALL have port BrAddr26, input, 26, B/BL word offset, signed.
REQ-010 SHALL have port CondAddr19, input, 19, CBZ/B.cond word offset, signed.
REQ-011 SHALL have port Db_br, input, 64, register branch target.
REQ-012 SHALL have port imem_data, input, 32, instruction read combinationally at imem_addr.
REQ-013 SHALL have port imem_addr, output, 64, current fetch PC.
REQ-014 SHALL have port instr_D, output, 32, IF/ID instruction to decode/datapath.
REQ-015 SHALL have port pc_D, output, 64, IF/ID PC of instr_D.
REQ-016 SHALL have port valid_D, output, 1, instr_D is a real fetched instruction (0 = bubble).

Function
REQ-017 SHALL hold PC register; imem_addr equals PC combinationally.
REQ-018 SHALL compute seq_pc = PC + 4, modulo 2^64 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-019 SHALL compute rel_target = pc_D + (sign-extended selected offset << 2), modulo 2^64.
REQ-020 SHALL compute reg_target = {Db_br[63:2], 2'b00}; br_reg overrides uncond_br.
REQ-021 SHALL apply per-cycle priority: reset > take_branch > stall > normal.
REQ-022 take_branch: PC <= target; IF/ID <= {NOP_INSTR, pc_D unchanged, valid_D=0} (squash wrong-path fetch); stall ignored that cycle.
REQ-023 stall (no branch): PC, instr_D, pc_D, valid_D hold.
REQ-024 normal: PC <= seq_pc; instr_D <= imem_data; pc_D <= PC; valid_D <= 1.
REQ-025 SHALL give one-cycle fetch-to-decode latency; taken-branch penalty exactly one bubble.
REQ-026 Consecutive take_branch cycles SHALL each redirect; every one inserts a bubble.
REQ-027 take_branch SHALL only be honoured using current pc_D regardless of valid_D; qualifying it is decode's responsibility.
REQ-028 PC[1:0] SHALL always be 2'b00.

Reset
REQ-029 On reset high at a clock edge: PC <= 0, instr_D <= NOP_INSTR, pc_D <= 0, valid_D <= 0, overriding stall and take_branch.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard pending state; first fetch after reset release is address 0.
REQ-031 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-032 Reset 2 cycles, release, imem returns 32'hA0..A3 at 0,4,8,C -> imem_addr 0,4,8,C; instr_D lags one cycle, valid_D=1 from first post-reset edge.
REQ-033 pc_D=0x10, uncond_br=1, BrAddr26=-2 (26'h3FFFFFE), take_branch=1 -> next imem_addr 0x08, instr_D=8B1F03FF, valid_D=0.
REQ-034 pc_D=0x20, CondAddr19=3, uncond_br=0, take_branch=1 with stall=1 -> imem_addr 0x2C (branch wins), bubble in IF/ID.
REQ-035 br_reg=1, Db_br=64'h1003, take_branch=1 -> imem_addr 0x1000.
REQ-036 stall held 3 cycles at PC=0x40 -> imem_addr, instr_D, pc_D unchanged; release -> PC 0x44.
REQ-037 PC forced via branch to 64'hFFFF_FFFF_FFFF_FFFC, normal fetch -> next imem_addr 0; reset asserted with take_branch=1 -> PC 0, valid_D=0.
